// File: rtl/ape_mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CH requesters onto one memory port,
// with an in-order ID FIFO that routes responses back to the issuing channel.
module ape_mem_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_add_i,
    input  logic [NUM_CH-1:0]        ch_opc_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
    output logic [NUM_CH-1:0]        ch_gnt_o,
    output logic [NUM_CH-1:0]        ch_rvalid_o,
    output logic [DATA_W-1:0]        ch_rdata_o,
    output logic                     mem_req_o,
    output logic [ADDR_W-1:0]        mem_add_o,
    output logic                     mem_opc_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt_o,
    output logic                     err_o
);

    localparam int IDW   = $clog2(NUM_CH);
    localparam int IDW1  = IDW + 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   lock_ch;
    logic             locked;
    logic [IDW-1:0]   sel;
    logic [IDW-1:0]   rr_win;
    logic [IDW1-1:0]  cand_sum;
    logic [IDW-1:0]   cand;
    logic             rr_found;
    logic             sel_req;
    logic             slot_free;
    logic             hs;
    logic             pop;

    logic [IDW-1:0]   id_fifo [MAX_OUTST];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [IDW-1:0]   head_id;
    logic [CNT_W-1:0] cnt;
    logic             err;

    // Round-robin search upward from rr_ptr, wrapping at NUM_CH.
    always_comb begin
        rr_win   = rr_ptr;
        rr_found = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand_sum = {1'b0, rr_ptr} + IDW1'(i);
            if (cand_sum >= IDW1'(NUM_CH)) begin
                cand_sum = cand_sum - IDW1'(NUM_CH);
            end
            cand = cand_sum[IDW-1:0];
            if (!rr_found && ch_req_i[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    // A locked channel only competes with itself; if it drops its request,
    // the port idles for one cycle while the lock clears.
    always_comb begin
        sel     = rr_win;
        sel_req = rr_found;
        if (locked) begin
            sel     = lock_ch;
            sel_req = ch_req_i[lock_ch];
        end
    end

    assign slot_free = (cnt < CNT_W'(MAX_OUTST));
    assign mem_req_o = !rst_i && sel_req && slot_free;
    assign hs        = mem_req_o && mem_gnt_i;
    assign pop       = !rst_i && mem_rvalid_i && (cnt != '0);
    assign head_id   = id_fifo[rptr];

    assign mem_add_o   = ch_add_i[int'(sel)*ADDR_W +: ADDR_W];
    assign mem_opc_o   = ch_opc_i[sel];
    assign mem_wdata_o = ch_wdata_i[int'(sel)*DATA_W +: DATA_W];

    always_comb begin
        ch_gnt_o         = '0;
        ch_gnt_o[sel]    = hs;
        ch_rvalid_o      = '0;
        ch_rvalid_o[head_id] = pop;
        ch_rdata_o       = pop ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            locked  <= 1'b0;
            lock_ch <= '0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            err     <= 1'b0;
        end else begin
            locked  <= mem_req_o && !mem_gnt_i;
            lock_ch <= sel;
            if (hs) begin
                rr_ptr        <= (sel == IDW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
                id_fifo[wptr] <= sel;
                wptr          <= (wptr == PTR_W'(MAX_OUTST - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PTR_W'(MAX_OUTST - 1)) ? '0 : rptr + 1'b1;
            end
            if (hs && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!hs && pop) begin
                cnt <= cnt - 1'b1;
            end
            if (mem_rvalid_i && (cnt == '0)) begin
                err <= 1'b1;
            end
        end
    end

    assign outst_cnt_o = cnt;
    assign err_o       = err;

endmodule

// File: tb/tb_ape_mem_arbiter.sv
// Directed self-checking bench for ape_mem_arbiter (2 channels, 4 outstanding).
module tb_ape_mem_arbiter;

    localparam int NUM_CH    = 2;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*ADDR_W-1:0] ch_add;
    logic [NUM_CH-1:0]        ch_opc;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH-1:0]        ch_rvalid;
    logic [DATA_W-1:0]        ch_rdata;
    logic                     mem_req;
    logic [ADDR_W-1:0]        mem_add;
    logic                     mem_opc;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_gnt;
    logic                     mem_rvalid;
    logic [DATA_W-1:0]        mem_rdata;
    logic [2:0]               outst_cnt;
    logic                     err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [1:0] exp_rv [3] = '{2'b10, 2'b01, 2'b10};
    logic [1:0] exp_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    ape_mem_arbiter #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ch_req_i     (ch_req),
        .ch_add_i     (ch_add),
        .ch_opc_i     (ch_opc),
        .ch_wdata_i   (ch_wdata),
        .ch_gnt_o     (ch_gnt),
        .ch_rvalid_o  (ch_rvalid),
        .ch_rdata_o   (ch_rdata),
        .mem_req_o    (mem_req),
        .mem_add_o    (mem_add),
        .mem_opc_o    (mem_opc),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .outst_cnt_o  (outst_cnt),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        ch_req     = 2'b11;
        ch_add     = {32'h0000_2000, 32'h0000_1000};
        ch_opc     = 2'b10;
        ch_wdata   = {32'h0000_BBBB, 32'h0000_AAAA};
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = '0;

        // Outputs held low while reset is high, even with live inputs.
        cycle();
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_gnt", 64'(ch_gnt), 64'd0);
        check("rst_rvalid", 64'(ch_rvalid), 64'd0);
        cycle();
        rst = 1'b0; ch_req = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("rst_cnt", 64'(outst_cnt), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        // Round-robin fairness, filling to MAX_OUTST.
        ch_req = 2'b11; mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_gnt", 64'(ch_gnt), 64'(exp_rr[i]));
            if (i == 1) begin
                check("rr_add1", 64'(mem_add), 64'h2000);
                check("rr_opc1", 64'(mem_opc), 64'd1);
                check("rr_wdata1", 64'(mem_wdata), 64'hBBBB);
            end
            cycle();
            check("rr_cnt", 64'(outst_cnt), 64'(i + 1));
        end

        // Full: no request; a response frees a slot only from the next cycle.
        #1;
        check("full_req", 64'(mem_req), 64'd0);
        check("full_gnt", 64'(ch_gnt), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h11;
        #1;
        check("full_rvalid", 64'(ch_rvalid), 64'b01);
        check("full_rdata", 64'(ch_rdata), 64'h11);
        check("full_nobypass", 64'(mem_req), 64'd0);
        cycle();
        check("full_cnt3", 64'(outst_cnt), 64'd3);
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        #1;
        check("full_reassert", 64'(mem_req), 64'd1);
        check("full_nogrant", 64'(ch_gnt), 64'd0);
        check("idle_rdata", 64'(ch_rdata), 64'd0);
        cycle();

        // In-order routing of remaining IDs 1,0,1.
        ch_req = 2'b00;
        for (int j = 0; j < 3; j++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA + 32'(j);
            #1;
            check("order_rvalid", 64'(ch_rvalid), 64'(exp_rv[j]));
            check("order_rdata", 64'(ch_rdata), 64'(32'hA + 32'(j)));
            cycle();
            check("order_cnt", 64'(outst_cnt), 64'(2 - j));
        end
        mem_rvalid = 1'b0;

        // Single grant to ch0 moves rr_ptr to 1, then return it.
        ch_req = 2'b01; mem_gnt = 1'b1;
        #1;
        check("solo_gnt", 64'(ch_gnt), 64'b01);
        cycle();
        ch_req = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        #1;
        check("solo_rvalid", 64'(ch_rvalid), 64'b01);
        cycle();
        check("solo_cnt", 64'(outst_cnt), 64'd0);
        mem_rvalid = 1'b0;

        // Lock: ch0 waits 3 cycles; ch1 joining must not steal it.
        ch_req = 2'b01; mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("lock_req", 64'(mem_req), 64'd1);
            check("lock_add", 64'(mem_add), 64'h1000);
            check("lock_nogrant", 64'(ch_gnt), 64'd0);
            cycle();
        end
        ch_req = 2'b11; mem_gnt = 1'b1;
        #1;
        check("lock_gnt", 64'(ch_gnt), 64'b01);
        check("lock_add_gnt", 64'(mem_add), 64'h1000);
        check("lock_opc", 64'(mem_opc), 64'd0);
        cycle();
        check("lock_cnt", 64'(outst_cnt), 64'd1);

        ch_req = 2'b10;
        #1;
        check("sim_pre_gnt", 64'(ch_gnt), 64'b10);
        cycle();
        check("sim_pre_cnt", 64'(outst_cnt), 64'd2);

        // Handshake and response together at count 2.
        ch_req = 2'b01; mem_rvalid = 1'b1; mem_rdata = 32'hD;
        #1;
        check("sim_gnt", 64'(ch_gnt), 64'b01);
        check("sim_rvalid", 64'(ch_rvalid), 64'b01);
        check("sim_rdata", 64'(ch_rdata), 64'hD);
        cycle();
        check("sim_cnt", 64'(outst_cnt), 64'd2);

        mem_rvalid = 1'b0; ch_req = 2'b10;
        #1;
        check("fill3_gnt", 64'(ch_gnt), 64'b10);
        cycle();
        check("fill3_cnt", 64'(outst_cnt), 64'd3);

        ch_req = 2'b00; mem_gnt = 1'b0;
        for (int j = 0; j < 3; j++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h21 + 32'(j);
            #1;
            check("order2_rvalid", 64'(ch_rvalid), 64'(exp_rv[j]));
            check("order2_rdata", 64'(ch_rdata), 64'(32'h21 + 32'(j)));
            cycle();
        end
        check("order2_cnt", 64'(outst_cnt), 64'd0);

        // Spurious response.
        mem_rdata = 32'h99;
        #1;
        check("spur_rvalid", 64'(ch_rvalid), 64'd0);
        check("spur_rdata", 64'(ch_rdata), 64'd0);
        cycle();
        check("spur_err", 64'(err), 64'd1);
        check("spur_cnt", 64'(outst_cnt), 64'd0);
        mem_rvalid = 1'b0;

        // Three outstanding, then reset mid-operation.
        ch_req = 2'b11; mem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("pre_rst_gnt", 64'(ch_gnt), 64'(exp_rr[i]));
            cycle();
        end
        check("pre_rst_cnt", 64'(outst_cnt), 64'd3);
        check("err_sticky", 64'(err), 64'd1);
        rst = 1'b1; mem_rvalid = 1'b1;
        #1;
        check("mid_rst_req", 64'(mem_req), 64'd0);
        check("mid_rst_gnt", 64'(ch_gnt), 64'd0);
        check("mid_rst_rvalid", 64'(ch_rvalid), 64'd0);
        cycle();
        check("post_rst_cnt", 64'(outst_cnt), 64'd0);
        check("post_rst_err", 64'(err), 64'd0);

        // Stale response for a discarded ID is spurious.
        rst = 1'b0; ch_req = 2'b00; mem_gnt = 1'b0;
        #1;
        check("stale_rvalid", 64'(ch_rvalid), 64'd0);
        cycle();
        check("stale_err", 64'(err), 64'd1);
        mem_rvalid = 1'b0;

        ch_req = 2'b11; mem_gnt = 1'b1;
        #1;
        check("post_rst_rr", 64'(ch_gnt), 64'b01);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
